// File: rtl/unidade_controle_multijogador_pkg.sv
// rtl/unidade_controle_multijogador_pkg.sv - state and end-reason encodings for the multiplayer game control
// Contents:
//   estado_t      4-bit state codes, also shown on the debug display
//   motivo_t      end-of-game reason codes
//   DB_INVALIDO   debug code shown for an undefined state register value
//   conta_tempo   1 for states in which the active player's timer runs
//   estado_valido 1 for codes that belong to estado_t
package unidade_controle_multijogador_pkg;

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    INICIA_ELEMENTOS = 4'h1,
    ESPERA           = 4'h2,
    REGISTRA         = 4'h3,
    COMPARA          = 4'h4,
    PAUSA            = 4'h5,
    GERA_JOGADA      = 4'h6,
    TROCA_JOGADOR    = 4'h7,
    FIM_JOGADA       = 4'h9,
    CONTA_PONTO      = 4'hA,
    DECRESCE         = 4'hE,
    FIM              = 4'hF
  } estado_t;

  typedef enum logic [1:0] {
    MOTIVO_NENHUM  = 2'b00,
    MOTIVO_TEMPO   = 2'b01,
    MOTIVO_ERROS   = 2'b10,
    MOTIVO_RODADAS = 2'b11
  } motivo_t;

  localparam logic [3:0] DB_INVALIDO = 4'hD;

  function automatic logic conta_tempo(input estado_t e);
    return e inside {ESPERA, REGISTRA, COMPARA, DECRESCE, CONTA_PONTO,
                     GERA_JOGADA, TROCA_JOGADOR, FIM_JOGADA};
  endfunction

  function automatic logic estado_valido(input logic [3:0] c);
    return c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                     4'h9, 4'hA, 4'hE, 4'hF};
  endfunction

endpackage

// File: rtl/unidade_controle_multijogador_contador.sv
// rtl/unidade_controle_multijogador_contador.sv - modulo-M counter with clear, enable and wrap pulse
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   zera           synchronous clear (wins over conta)
//   conta          count enable
//   valor          current count, 0..M-1
//   valor_prox     value the counter takes at the next edge
//   fim_ciclo      1 when the next edge wraps M-1 back to 0
module contador_modulo_m #(
  parameter int M = 2,
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor,
  output logic [W-1:0] valor_prox,
  output logic         fim_ciclo
);

  assign fim_ciclo = conta && !zera && (valor == W'(M - 1));

  always_comb begin
    valor_prox = valor;
    if (zera || fim_ciclo)
      valor_prox = '0;
    else if (conta)
      valor_prox = valor + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      valor <= '0;
    else
      valor <= valor_prox;
  end

endmodule

// File: rtl/unidade_controle_multijogador.sv
// rtl/unidade_controle_multijogador.sv - Moore game-control FSM for N players taking turns
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   iniciar          start a game (inicial only)
//   terminar         leave fim (fim only)
//   pausar           pause level
//   temJogada        move available
//   acertou          compare result, valid in compara
//   fimT[N_JOG]      per-player timer expired
//   registraR/zeraR  move register load / clear
//   zeraT/zeraP/zeraG clear timers / scores / move generator
//   geraNova         request new target move
//   contaT[N_JOG]    active player's timer enable
//   decresceT[N_JOG] penalty pulse to active player's timer
//   contaP[N_JOG]    score pulse to active player's counter
//   jogador_atual    active player index
//   motivo_fim       end reason (none/timeout/errors/rounds)
//   db_estado        state code for the debug display
module unidade_controle_multijogador
  import unidade_controle_multijogador_pkg::*;
#(
  parameter int N_JOG           = 2,
  parameter int W_JOG           = 1,
  parameter int MAX_ERROS       = 3,
  parameter int W_ERR           = 2,
  parameter int N_RODADAS       = 8,
  parameter int W_ROD           = 4,
  parameter int MODO_PENALIDADE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             terminar,
  input  logic             pausar,
  input  logic             temJogada,
  input  logic             acertou,
  input  logic [N_JOG-1:0] fimT,
  output logic             registraR,
  output logic             zeraR,
  output logic             zeraT,
  output logic             zeraP,
  output logic             zeraG,
  output logic             geraNova,
  output logic [N_JOG-1:0] contaT,
  output logic [N_JOG-1:0] decresceT,
  output logic [N_JOG-1:0] contaP,
  output logic [W_JOG-1:0] jogador_atual,
  output logic [1:0]       motivo_fim,
  output logic [3:0]       db_estado
);

  // With no round limit the round counter simply wraps over its full width.
  localparam int M_ROD = (N_RODADAS == 0) ? (1 << W_ROD) : N_RODADAS;

  estado_t          estado, estado_prox;
  logic [W_JOG-1:0] jog_prox;
  logic             jog_volta;
  logic [W_ROD-1:0] rodadas_unused, rodadas_prox_unused;
  logic             rod_limite;
  logic [W_ERR-1:0] erros [N_JOG];
  logic [W_ERR-1:0] erro_atual, erro_inc;
  logic             lim_erros, lim_rodadas, tempo_esgotado;
  logic [N_JOG-1:0] sel_prox;

  contador_modulo_m #(.M(N_JOG), .W(W_JOG)) u_jogador (
    .clock      (clock),
    .reset      (reset),
    .zera       (estado == INICIA_ELEMENTOS),
    .conta      (estado == TROCA_JOGADOR),
    .valor      (jogador_atual),
    .valor_prox (jog_prox),
    .fim_ciclo  (jog_volta)
  );

  // Its wrap pulse marks the edge where the round count reaches N_RODADAS.
  contador_modulo_m #(.M(M_ROD), .W(W_ROD)) u_rodadas (
    .clock      (clock),
    .reset      (reset),
    .zera       (estado == INICIA_ELEMENTOS),
    .conta      (jog_volta),
    .valor      (rodadas_unused),
    .valor_prox (rodadas_prox_unused),
    .fim_ciclo  (rod_limite)
  );

  assign tempo_esgotado = fimT[jogador_atual];
  assign erro_atual     = erros[jogador_atual];
  assign erro_inc       = (erro_atual == '1) ? erro_atual : erro_atual + W_ERR'(1);
  assign lim_erros      = (MAX_ERROS != 0) && (erro_inc == W_ERR'(MAX_ERROS));
  assign lim_rodadas    = (N_RODADAS != 0) && rod_limite;
  assign sel_prox       = N_JOG'(1) << jog_prox;

  assign db_estado = estado_valido(4'(estado)) ? 4'(estado) : DB_INVALIDO;

  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL:          if (iniciar) estado_prox = INICIA_ELEMENTOS;
      INICIA_ELEMENTOS: estado_prox = ESPERA;
      ESPERA: begin
        if (tempo_esgotado)  estado_prox = FIM;
        else if (pausar)     estado_prox = PAUSA;
        else if (temJogada)  estado_prox = REGISTRA;
      end
      PAUSA:            if (!pausar) estado_prox = ESPERA;
      REGISTRA:         estado_prox = COMPARA;
      COMPARA:          estado_prox = acertou ? CONTA_PONTO : DECRESCE;
      DECRESCE:         estado_prox = lim_erros ? FIM : FIM_JOGADA;
      CONTA_PONTO:      estado_prox = GERA_JOGADA;
      GERA_JOGADA:      estado_prox = TROCA_JOGADOR;
      TROCA_JOGADOR:    estado_prox = lim_rodadas ? FIM : FIM_JOGADA;
      FIM_JOGADA:       estado_prox = ESPERA;
      FIM:              if (terminar) estado_prox = INICIAL;
      default:          estado_prox = INICIAL;
    endcase
  end

  // Outputs are registered from the next state and next player, so they always
  // equal the Moore decode of the state register without a decode delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      registraR  <= 1'b0;
      zeraR      <= 1'b0;
      zeraT      <= 1'b0;
      zeraP      <= 1'b0;
      zeraG      <= 1'b0;
      geraNova   <= 1'b0;
      contaT     <= '0;
      decresceT  <= '0;
      contaP     <= '0;
      motivo_fim <= MOTIVO_NENHUM;
      for (int i = 0; i < N_JOG; i++) erros[i] <= '0;
    end else begin
      estado    <= estado_prox;
      registraR <= (estado_prox == REGISTRA);
      zeraR     <= (estado_prox == FIM_JOGADA);
      zeraT     <= (estado_prox == INICIA_ELEMENTOS);
      zeraP     <= (estado_prox == INICIA_ELEMENTOS);
      zeraG     <= (estado_prox == INICIA_ELEMENTOS);
      geraNova  <= (estado_prox == INICIA_ELEMENTOS) || (estado_prox == GERA_JOGADA);
      contaT    <= conta_tempo(estado_prox) ? sel_prox : '0;
      decresceT <= ((estado_prox == DECRESCE) && (MODO_PENALIDADE != 0)) ? sel_prox : '0;
      contaP    <= (estado_prox == CONTA_PONTO) ? sel_prox : '0;

      if (estado == INICIA_ELEMENTOS) begin
        motivo_fim <= MOTIVO_NENHUM;
        for (int i = 0; i < N_JOG; i++) erros[i] <= '0;
      end

      if (estado == DECRESCE)
        erros[jogador_atual] <= erro_inc;

      // The reason is latched on entry to fim from whichever state ended the game.
      if (estado_prox == FIM && estado != FIM) begin
        case (estado)
          ESPERA:        motivo_fim <= MOTIVO_TEMPO;
          DECRESCE:      motivo_fim <= MOTIVO_ERROS;
          TROCA_JOGADOR: motivo_fim <= MOTIVO_RODADAS;
          default:       motivo_fim <= motivo_fim;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unidade_controle_multijogador.sv
// tb/tb_unidade_controle_multijogador.sv - directed bench for unidade_controle_multijogador
module tb_unidade_controle_multijogador;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0, terminar = 1'b0, pausar = 1'b0, temJogada = 1'b0, acertou = 1'b0;
  logic [1:0] fimT  = 2'b00;
  logic [2:0] fimT3 = 3'b000;

  always #5 clock = ~clock;

  // default instance: 2 players
  logic       a_registraR, a_zeraR, a_zeraT, a_zeraP, a_zeraG, a_geraNova;
  logic [1:0] a_contaT, a_decresceT, a_contaP, a_motivo;
  logic [0:0] a_jog;
  logic [3:0] a_db;

  // 3 players, 2 rounds
  logic       b_registraR, b_zeraR, b_zeraT, b_zeraP, b_zeraG, b_geraNova;
  logic [2:0] b_contaT, b_decresceT, b_contaP;
  logic [1:0] b_jog, b_motivo;
  logic [3:0] b_db;

  // no time penalty
  logic       c_registraR, c_zeraR, c_zeraT, c_zeraP, c_zeraG, c_geraNova;
  logic [1:0] c_contaT, c_decresceT, c_contaP, c_motivo;
  logic [0:0] c_jog;
  logic [3:0] c_db;

  unidade_controle_multijogador dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .terminar(terminar), .pausar(pausar),
    .temJogada(temJogada), .acertou(acertou), .fimT(fimT),
    .registraR(a_registraR), .zeraR(a_zeraR), .zeraT(a_zeraT), .zeraP(a_zeraP), .zeraG(a_zeraG),
    .geraNova(a_geraNova), .contaT(a_contaT), .decresceT(a_decresceT), .contaP(a_contaP),
    .jogador_atual(a_jog), .motivo_fim(a_motivo), .db_estado(a_db)
  );

  unidade_controle_multijogador #(.N_JOG(3), .W_JOG(2), .N_RODADAS(2)) dut3 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .terminar(terminar), .pausar(pausar),
    .temJogada(temJogada), .acertou(acertou), .fimT(fimT3),
    .registraR(b_registraR), .zeraR(b_zeraR), .zeraT(b_zeraT), .zeraP(b_zeraP), .zeraG(b_zeraG),
    .geraNova(b_geraNova), .contaT(b_contaT), .decresceT(b_decresceT), .contaP(b_contaP),
    .jogador_atual(b_jog), .motivo_fim(b_motivo), .db_estado(b_db)
  );

  unidade_controle_multijogador #(.MODO_PENALIDADE(0)) dut_np (
    .clock(clock), .reset(reset), .iniciar(iniciar), .terminar(terminar), .pausar(pausar),
    .temJogada(temJogada), .acertou(acertou), .fimT(fimT),
    .registraR(c_registraR), .zeraR(c_zeraR), .zeraT(c_zeraT), .zeraP(c_zeraP), .zeraG(c_zeraG),
    .geraNova(c_geraNova), .contaT(c_contaT), .decresceT(c_decresceT), .contaP(c_contaP),
    .jogador_atual(c_jog), .motivo_fim(c_motivo), .db_estado(c_db)
  );

  int n_vetores = 0;
  int n_erros   = 0;

  task automatic confere(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_vetores++;
    if (obtido !== esperado) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h", tag, obtido, esperado);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // reset, start, and land in espera with player 0 active
  task automatic inicia_jogo();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  // from espera, play one move and stop in contaPonto / decresce
  task automatic joga(input logic acerto);
    temJogada = 1'b1;
    acertou = acerto;
    tick();
    temJogada = 1'b0;
    tick();
    tick();
  endtask

  logic [2:0] tab_contaP  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] tab_contaT  [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [1:0] tab_jogador [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  initial begin
    // 1: reset state and one correct move
    tick();
    tick();
    confere("rst db", a_db, 4'h0);
    confere("rst outs", {a_registraR, a_zeraR, a_zeraT, a_zeraP, a_zeraG, a_geraNova,
                         a_contaT, a_decresceT, a_contaP, a_jog, a_motivo}, 0);
    reset = 1'b0;
    tick();
    confere("idle db", a_db, 4'h0);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    confere("t1 db 1", a_db, 4'h1);
    confere("t1 zeros", {a_zeraT, a_zeraP, a_zeraG, a_geraNova}, 4'hF);
    tick();
    confere("t1 db 2", a_db, 4'h2);
    confere("t1 contaT 01", a_contaT, 2'b01);
    temJogada = 1'b1;
    acertou = 1'b1;
    tick();
    temJogada = 1'b0;
    confere("t1 db 3", a_db, 4'h3);
    confere("t1 registraR", a_registraR, 1'b1);
    tick();
    confere("t1 db 4", a_db, 4'h4);
    tick();
    confere("t1 db A", a_db, 4'hA);
    confere("t1 contaP", a_contaP, 2'b01);
    tick();
    confere("t1 db 6", a_db, 4'h6);
    confere("t1 geraNova", a_geraNova, 1'b1);
    tick();
    confere("t1 db 7", a_db, 4'h7);
    confere("t1 jog in troca", a_jog, 1'b0);
    tick();
    confere("t1 db 9", a_db, 4'h9);
    confere("t1 jog 1", a_jog, 1'b1);
    confere("t1 contaT 10", a_contaT, 2'b10);
    confere("t1 zeraR", a_zeraR, 1'b1);
    tick();
    confere("t1 back to 2", a_db, 4'h2);

    // 2: error limit for player 0
    inicia_jogo();
    for (int k = 0; k < 3; k++) begin
      joga(1'b0);
      confere("t2 db E", a_db, 4'hE);
      confere("t2 decresceT", a_decresceT, 2'b01);
      tick();
      if (k < 2) begin
        confere("t2 db 9", a_db, 4'h9);
        confere("t2 jog stays 0", a_jog, 1'b0);
        tick();
      end
    end
    confere("t2 db F", a_db, 4'hF);
    confere("t2 motivo 10", a_motivo, 2'b10);
    confere("t2 jog 0", a_jog, 1'b0);
    confere("t2 contaT off", a_contaT, 2'b00);
    tick();
    confere("t2 holds F", a_db, 4'hF);
    terminar = 1'b1;
    tick();
    terminar = 1'b0;
    confere("t2 db 0", a_db, 4'h0);

    // 3: other player's timeout ignored; own timeout beats a move
    inicia_jogo();
    fimT = 2'b10;
    tick();
    confere("t3 ignore fimT", a_db, 4'h2);
    fimT = 2'b01;
    temJogada = 1'b1;
    tick();
    fimT = 2'b00;
    temJogada = 1'b0;
    confere("t3 db F", a_db, 4'hF);
    confere("t3 motivo 01", a_motivo, 2'b01);
    confere("t3 jog 0", a_jog, 1'b0);

    // 4: pause beats a move, stops the timer, and resumes
    inicia_jogo();
    pausar = 1'b1;
    temJogada = 1'b1;
    tick();
    temJogada = 1'b0;
    confere("t4 db 5", a_db, 4'h5);
    confere("t4 contaT 00", a_contaT, 2'b00);
    tick();
    confere("t4 stays 5", a_db, 4'h5);
    pausar = 1'b0;
    tick();
    confere("t4 db 2", a_db, 4'h2);
    confere("t4 contaT back", a_contaT, 2'b01);

    // 5: 3 players, 2 rounds
    inicia_jogo();
    for (int m = 0; m < 6; m++) begin
      joga(1'b1);
      confere("t5 db A", b_db, 4'hA);
      confere("t5 contaP", b_contaP, tab_contaP[m]);
      tick();
      tick();
      tick();
      if (m < 5) begin
        confere("t5 db 9", b_db, 4'h9);
        confere("t5 jog", b_jog, tab_jogador[m]);
        confere("t5 contaT", b_contaT, tab_contaT[m]);
        tick();
      end
    end
    confere("t5 db F", b_db, 4'hF);
    confere("t5 motivo 11", b_motivo, 2'b11);
    confere("t5 jog 0", b_jog, 2'd0);
    confere("t5 contaT off", b_contaT, 3'b000);
    terminar = 1'b1;
    tick();
    terminar = 1'b0;
    confere("t5 db 0", b_db, 4'h0);

    // 6: asynchronous reset in compara, then a wrong move without penalty
    inicia_jogo();
    temJogada = 1'b1;
    acertou = 1'b0;
    tick();
    temJogada = 1'b0;
    tick();
    confere("t6 in compara", a_db, 4'h4);
    reset = 1'b1;
    #1;
    confere("t6 async db", a_db, 4'h0);
    confere("t6 async outs", {a_registraR, a_zeraR, a_zeraT, a_zeraP, a_zeraG, a_geraNova,
                              a_contaT, a_decresceT, a_contaP, a_jog, a_motivo}, 0);
    tick();
    confere("t6 held db", a_db, 4'h0);
    inicia_jogo();
    joga(1'b0);
    confere("t6 np db E", c_db, 4'hE);
    confere("t6 np no pulse", c_decresceT, 2'b00);
    confere("t6 pen pulse", a_decresceT, 2'b01);
    tick();
    confere("t6 np db 9", c_db, 4'h9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
